// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving the DataPath control inputs.
// NOP/JUMP take 2 cycles, STORE/ADD/SUB 3, LOAD 4; there is no stall input, and HALT is left only by reset.
module control_unit #(
   parameter int         WIDTH    = 16,
   parameter int         D_ADDR_W = 8,
   parameter int         R_ADDR_W = 4,
   parameter int         PC_W     = 8,
   parameter logic [3:0] A_ADD    = 4'd1,
   parameter logic [3:0] A_SUB    = 4'd2
) (
   input  logic                clk,
   input  logic                reset_n,
   output logic [PC_W-1:0]     I_addr,
   input  logic [WIDTH-1:0]    I_data,
   output logic [D_ADDR_W-1:0] D_addr,
   output logic                D_wr,
   output logic                RF_s,
   output logic                RF_W_en,
   output logic [R_ADDR_W-1:0] RF_W_addr,
   output logic [R_ADDR_W-1:0] RF_A_addr,
   output logic [R_ADDR_W-1:0] RF_B_addr,
   output logic [3:0]          ALU_sel,
   output logic                halted,
   output logic                err
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_LD_ADDR, S_LD_WB, S_STORE, S_ALU_WB, S_HALT
   } state_t;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_JUMP  = 4'h5;
   localparam logic [3:0] OP_HALT  = 4'hF;

   state_t          state, state_nxt;
   logic [PC_W-1:0] pc;
   logic [WIDTH-1:0] ir;
   logic [3:0]      in_op, ir_op;
   logic            in_legal;

   assign in_op    = I_data[15:12];
   assign ir_op    = ir[15:12];
   assign in_legal = in_op inside {OP_NOP, OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_JUMP, OP_HALT};
   assign I_addr   = pc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_FETCH;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:   state_nxt = S_DECODE;
         S_DECODE: begin
            case (in_op)
               OP_NOP, OP_JUMP: state_nxt = S_FETCH;
               OP_LOAD:         state_nxt = S_LD_ADDR;
               OP_STORE:        state_nxt = S_STORE;
               OP_ADD, OP_SUB:  state_nxt = S_ALU_WB;
               default:         state_nxt = S_HALT;
            endcase
         end
         S_LD_ADDR: state_nxt = S_LD_WB;
         S_LD_WB, S_STORE, S_ALU_WB: state_nxt = S_FETCH;
         S_HALT:    state_nxt = S_HALT;
         default:   state_nxt = S_FETCH;
      endcase
   end

   // A JUMP decoded in DECODE overrides the increment done during FETCH.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc  <= '0;
         ir  <= '0;
         err <= 1'b0;
      end else begin
         if (state == S_FETCH) pc <= pc + PC_W'(1);
         if (state == S_DECODE) begin
            ir <= I_data;
            if (in_op == OP_JUMP) pc  <= PC_W'(I_data[7:0]);
            if (!in_legal)        err <= 1'b1;
         end
      end
   end

   // Address/select outputs derive only from IR, so they hold steady across every write cycle.
   always_comb begin
      D_wr      = (state == S_STORE);
      RF_W_en   = (state == S_LD_WB) || (state == S_ALU_WB);
      halted    = (state == S_HALT);
      D_addr    = D_ADDR_W'(ir[7:0]);
      RF_W_addr = R_ADDR_W'(ir[11:8]);
      RF_A_addr = (ir_op == OP_STORE) ? R_ADDR_W'(ir[11:8]) : R_ADDR_W'(ir[7:4]);
      RF_B_addr = R_ADDR_W'(ir[3:0]);
      RF_s      = (ir_op == OP_LOAD);
      ALU_sel   = (ir_op == OP_ADD) ? A_ADD : (ir_op == OP_SUB) ? A_SUB : 4'd0;
   end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: an ISA-level model predicts writes and per-cycle I_addr/halted/err;
// a negedge monitor pops expected writes as the DUT presents them.
module tb_control_unit;
   localparam logic [3:0] A_ADD = 4'd1;
   localparam logic [3:0] A_SUB = 4'd2;
   localparam int MAXT = 400;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  I_addr;
   logic [15:0] I_data;
   logic [7:0]  D_addr;
   logic        D_wr, RF_s, RF_W_en, halted, err;
   logic [3:0]  RF_W_addr, RF_A_addr, RF_B_addr, ALU_sel;

   control_unit #(.WIDTH(16), .D_ADDR_W(8), .R_ADDR_W(4), .PC_W(8),
                  .A_ADD(A_ADD), .A_SUB(A_SUB)) dut (
      .clk(clk), .reset_n(reset_n), .I_addr(I_addr), .I_data(I_data),
      .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s), .RF_W_en(RF_W_en),
      .RF_W_addr(RF_W_addr), .RF_A_addr(RF_A_addr), .RF_B_addr(RF_B_addr),
      .ALU_sel(ALU_sel), .halted(halted), .err(err));

   always #5 clk = ~clk;

   logic [15:0] rom [256];

   // Synchronous ROM: address sampled at the edge, data appears shortly after.
   always @(posedge clk) begin : rom_model
      logic [7:0] a;
      a = I_addr;
      #1 I_data = rom[a];
   end

   typedef struct {
      int       cyc;
      bit       st;
      bit       rf_s;
      bit [7:0] d_addr;
      bit [3:0] w, a, b, alu;
   } ev_t;

   ev_t      sb[$];
   bit [7:0] exp_ia [MAXT+1];
   bit       exp_h  [MAXT+1];
   bit       exp_e  [MAXT+1];
   int       vectors = 0, miscompares = 0;
   int       cyc = 0;
   bit       active = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
   endtask

   // Walks the program instruction by instruction using the cycles-per-instruction table.
   task automatic run_model(input int t);
      int        c = 1;
      int        n;
      bit [7:0]  pc = 8'd0, npc;
      bit [15:0] ins;
      bit [3:0]  op;
      ev_t       e;
      for (int k = 0; k <= MAXT; k++) begin exp_ia[k] = 0; exp_h[k] = 0; exp_e[k] = 0; end
      while (c <= t) begin
         ins = rom[pc];
         op  = ins[15:12];
         npc = pc + 8'd1;
         exp_ia[c] = pc;
         if (!(op inside {[4'h0:4'h5]})) begin
            for (int k = c + 1; k <= t; k++) begin
               exp_ia[k] = npc;
               exp_h[k]  = (k >= c + 2);
               exp_e[k]  = (k >= c + 2) && (op != 4'hF);
            end
            break;
         end
         n = (op == 4'h1) ? 4 : (op == 4'h0 || op == 4'h5) ? 2 : 3;
         for (int k = 1; k < n; k++) if (c + k <= t) exp_ia[c + k] = npc;
         e.cyc    = c + n - 1;
         e.st     = (op == 4'h2);
         e.rf_s   = (op == 4'h1);
         e.d_addr = ins[7:0];
         e.w      = ins[11:8];
         e.a      = (op == 4'h2) ? ins[11:8] : ins[7:4];
         e.b      = ins[3:0];
         e.alu    = (op == 4'h3) ? A_ADD : A_SUB;
         if (op inside {[4'h1:4'h4]} && e.cyc <= t) sb.push_back(e);
         pc = (op == 4'h5) ? ins[7:0] : npc;
         c += n;
      end
   endtask

   always @(negedge clk) begin : monitor
      ev_t e;
      if (!active) cyc = 0;
      else begin
         cyc++;
         chk("i_addr", I_addr, exp_ia[cyc]);
         chk("halted", halted, exp_h[cyc]);
         chk("err", err, exp_e[cyc]);
         chk("wr_exclusive", D_wr & RF_W_en, 0);
         if (D_wr || RF_W_en) begin
            if (sb.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_write: D_wr=%0b RF_W_en=%0b, none expected (cycle %0d)", D_wr, RF_W_en, cyc);
            end else begin
               e = sb.pop_front();
               chk("wr_cycle", cyc, e.cyc);
               chk("wr_kind_dwr", D_wr, e.st);
               if (e.st) begin
                  chk("st_d_addr", D_addr, e.d_addr);
                  chk("st_a_addr", RF_A_addr, e.a);
               end else begin
                  chk("wb_rf_s", RF_s, e.rf_s);
                  chk("wb_w_addr", RF_W_addr, e.w);
                  if (e.rf_s) chk("ld_d_addr", D_addr, e.d_addr);
                  else begin
                     chk("alu_a_addr", RF_A_addr, e.a);
                     chk("alu_b_addr", RF_B_addr, e.b);
                     chk("alu_sel", ALU_sel, e.alu);
                  end
               end
            end
         end else if (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            vectors++; miscompares++;
            $display("FAIL missing_write: no enable high, write expected (cycle %0d)", cyc);
         end
      end
   end

   task automatic run_prog(input int t);
      reset_n = 1'b0;
      sb.delete();
      run_model(t);
      @(posedge clk);
      #1 reset_n = 1'b1;
      active = 1'b1;
      repeat (t) @(posedge clk);
      #1 active = 1'b0;
      chk("sb_drained", sb.size(), 0);
   endtask

   // Drops reset in the write cycle of a single instruction at address 0.
   task automatic mid_reset(input logic [15:0] ins, input int wcyc);
      clear_rom();
      rom[0] = ins;
      reset_n = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (wcyc - 1) @(posedge clk);
      @(negedge clk);
      chk("pre_reset_en", D_wr | RF_W_en, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("reset_en_drop", D_wr | RF_W_en, 0);
      chk("reset_i_addr", I_addr, 0);
      @(posedge clk);
      #1 chk("no_late_write", D_wr | RF_W_en, 0);
      reset_n = 1'b1;
      chk("restart_ia0", I_addr, 0);
      @(posedge clk);
      #1 chk("restart_ia1", I_addr, 1);
   endtask

   initial begin
      reset_n = 1'b0;
      I_data  = 16'h0000;
      clear_rom();
      #3;
      chk("rst_i_addr", I_addr, 0);
      chk("rst_en", {D_wr, RF_W_en, RF_s}, 0);
      chk("rst_status", {halted, err}, 0);
      chk("rst_addrs", {D_addr, RF_W_addr, RF_A_addr, RF_B_addr, ALU_sel}, 0);

      rom[0] = 16'h100B; rom[1] = 16'h111B; rom[2] = 16'h4001; rom[3] = 16'hF000;
      run_prog(20);
      clear_rom(); rom[0] = 16'h20CD; rom[1] = 16'hF000;
      run_prog(12);
      clear_rom(); rom[3] = 16'h50FF;
      run_prog(40);
      clear_rom(); rom[0] = 16'h9123;
      run_prog(12);

      reset_n = 1'b0;
      #1;
      chk("halt_rst_err", err, 0);
      chk("halt_rst_halted", halted, 0);
      chk("halt_rst_ia", I_addr, 0);

      mid_reset(16'h1310, 4);
      mid_reset(16'h2A55, 3);
      mid_reset(16'h3512, 3);

      for (int p = 0; p < 20; p++) begin
         for (int i = 0; i < 256; i++) begin
            int       r;
            bit [3:0] op;
            r  = $urandom_range(0, 99);
            op = (r < 15) ? 4'h0 : (r < 35) ? 4'h1 : (r < 50) ? 4'h2 : (r < 65) ? 4'h3 :
                 (r < 80) ? 4'h4 : (r < 95) ? 4'h5 : (r < 98) ? 4'hF : 4'($urandom_range(6, 14));
            rom[i] = {op, 12'($urandom)};
         end
         run_prog(300);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle control FSM for the 16-bit core. Fetches instructions from a synchronous instruction ROM, decodes them, and drives every control input of the `DataPath` block (`D_addr`, `D_wr`, `RF_s`, `RF_W_en`, `RF_W_addr`, `RF_A_addr`, `RF_B_addr`, `ALU_sel`). It sits directly upstream of `DataPath`, and the top level connects its outputs straight to `DataPath` inputs.

## Interface
- WIDTH, 16, instruction width; equals the datapath word.
- D_ADDR_W, 8, data-memory address width.
- R_ADDR_W, 4, register-file address width.
- PC_W, 8, program counter and instruction-address width.
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- I_addr  out  PC_W  instruction ROM address; equals the PC register.
- I_data  in  WIDTH  ROM output; valid one cycle after I_addr is sampled.
- D_addr  out  D_ADDR_W  data memory address.
- D_wr  out  1  data memory write enable.
- RF_s  out  1  write-back select: 0 = ALU, 1 = data memory.
- RF_W_en  out  1  register-file write enable.
- RF_W_addr, RF_A_addr, RF_B_addr  out  R_ADDR_W each  register addresses.
- ALU_sel  out  4  ALU opcode, using `A_ADD`/`A_SUB` from instructions.vh.
- halted  out  1  high while in HALT.
- err  out  1  sticky; set on an illegal opcode.

## Operation
- Instruction fields (IR): op = IR[15:12], r = IR[11:8], a = IR[7:4], b = IR[3:0], imm = IR[7:0].
- Opcodes:
  - 0x0 NOP
  - 0x1 LOAD: R[r] <= M[imm]
  - 0x2 STORE: M[imm] <= R[r]
  - 0x3 ADD: R[r] <= R[a] + R[b]
  - 0x4 SUB: R[r] <= R[a] - R[b]
  - 0x5 JUMP: PC <= imm[PC_W-1:0]
  - 0xF HALT
  - any other value is illegal.
- States: FETCH, DECODE, LD_ADDR, LD_WB, STORE, ALU_WB, HALT.
- FETCH: the ROM samples I_addr at the end of this cycle; PC <= PC+1, wrapping modulo 2^PC_W.
- DECODE: IR <= I_data. Next state depends on I_data[15:12]:
  - NOP → FETCH
  - LOAD → LD_ADDR
  - STORE → STORE
  - ADD/SUB → ALU_WB
  - JUMP → FETCH, with PC <= imm (overrides the increment)
  - HALT → HALT
  - illegal → HALT with err <= 1
- LD_ADDR: D_addr = imm, RF_s = 1, RF_W_en = 0; the memory samples the address. → LD_WB.
- LD_WB: D_addr = imm, RF_s = 1, RF_W_addr = r, RF_W_en = 1. → FETCH.
- STORE: RF_A_addr = r, D_addr = imm, D_wr = 1 for exactly one cycle. → FETCH.
- ALU_WB: RF_A_addr = a, RF_B_addr = b, ALU_sel = `A_ADD`/`A_SUB`, RF_s = 0, RF_W_addr = r, RF_W_en = 1 for one cycle. → FETCH.
- HALT: absorbing state. Only reset leaves it.
- Address outputs are registered from IR fields and held between instructions. Enables (D_wr, RF_W_en) are 0 in every state not listed above.

## Timing
- Reset (asynchronous, immediate):
  - state = FETCH
  - PC = 0, IR = 0
  - all outputs 0 (ALU_sel = 0, halted = 0, err = 0)
- Cycles per instruction:
  - NOP, JUMP: 2
  - STORE, ADD, SUB: 3
  - LOAD: 4
  - illegal: 2 to reach HALT
- D_wr and RF_W_en are each high for exactly one clock per instruction and are never high together.
- On every write cycle, the address, select, and enable outputs are stable for the whole cycle; they come from registers or state decode, never from I_data.
- JUMP followed by FETCH: I_addr shows the target on the first FETCH cycle.
- PC = 2^PC_W-1 during FETCH: the next PC is 0.
- Reset asserted mid-instruction (for example during LD_WB or STORE): enables drop combinationally with reset. No partial write may occur after reset assertion.
- halted rises on the first HALT cycle and stays high.

## Test plan
- Reset, then release reset_n → I_addr = 0 and all enables 0; FETCH samples PC 0, with PC = 1 on the next cycle.
- ROM: LOAD r0,0x0B; LOAD r1,0x1B; SUB r0,r0,r1; HALT → RF_W_en pulses in cycles 4, 8, and 11 with RF_s = 1, 1, 0 respectively; ALU_sel = `A_SUB` in cycle 11; halted = 1 from cycle 14.
- STORE r0,0xCD → D_addr = 0xCD, RF_A_addr = 0, D_wr = 1 for one cycle only; RF_W_en stays 0 throughout.
- JUMP 0xFF at address 3, then NOP at 0xFF → I_addr sequence 3, 0xFF, 0x00.
- Opcode 0x9 → err = 1 and halted = 1 after 2 cycles; err stays high; no enable pulses.
- reset_n dropped during LD_WB → RF_W_en = 0 immediately and the register is not written; restart fetches from 0.
